// File: rtl/blackjack_pkg.sv
// Shared blackjack types: deck geometry, the dealt-card record and the dealer FSM states.
package blackjack_pkg;

  localparam int DECK_SIZE      = 52;
  localparam int CARDS_PER_SUIT = 13;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
    logic [3:0] points;
  } card_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    PROBE,
    DONE
  } dealer_state_t;

  // Ace counts high; J/Q/K count as ten.
  function automatic logic [3:0] rank_points(input logic [3:0] rank);
    if (rank == 4'd1) begin
      return 4'd11;
    end else if (rank >= 4'd11) begin
      return 4'd10;
    end else begin
      return rank;
    end
  endfunction

endpackage

// File: rtl/card_decoder.sv
// Combinational index-to-card mapping (suit = idx / 13, rank = idx % 13 + 1).
// Indices past the end of the deck decode to an all-zero card.
module card_decoder
  import blackjack_pkg::*;
(
  input  logic [5:0] idx_i,
  output card_t      card_o
);

  logic [2:0] suit_ge;
  logic [1:0] suit;
  logic [5:0] suit_base;
  logic [3:0] rank;

  // Thermometer of suit boundaries avoids a divider.
  for (genvar gi = 1; gi < 4; gi++) begin : g_suit_bound
    assign suit_ge[gi-1] = (idx_i >= 6'(gi * CARDS_PER_SUIT));
  end

  assign suit      = 2'(suit_ge[0]) + 2'(suit_ge[1]) + 2'(suit_ge[2]);
  assign suit_base = 6'(int'(suit) * CARDS_PER_SUIT);
  assign rank      = 4'(idx_i - suit_base) + 4'd1;

  always_comb begin
    card_o = '0;
    if (idx_i < 6'(DECK_SIZE)) begin
      card_o.rank   = rank;
      card_o.suit   = suit;
      card_o.points = rank_points(rank);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement, resolving RNG collisions by linear probing.
// Optional CARD_DEALER_REMAINING_EN exposes the remaining-card count as o_remaining.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int RNG_WIDTH = 6,
  parameter int DECK_SIZE = 52
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_deal,
  input  logic                 i_shuffle,
  output logic                 o_rngRequest,
  output logic [RNG_WIDTH-1:0] o_rngMax,
  input  logic [RNG_WIDTH-1:0] i_rngValue,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [3:0]           o_rank,
  output logic [1:0]           o_suit,
  output logic [3:0]           o_points,
  output logic                 o_empty,
  output logic                 o_dealError
`ifdef CARD_DEALER_REMAINING_EN
  ,output logic [5:0]          o_remaining
`endif
);

  dealer_state_t          state_q, state_d;
  logic [DECK_SIZE-1:0]   used_q, used_d;
  logic [5:0]             remaining_q, remaining_d;
  logic [5:0]             idx_q, idx_d;
  card_t                  card_q, card_d;
  logic                   dealerr_q, dealerr_d;
  logic                   empty_q, empty_d;

  card_t                  probe_card;
  logic [RNG_WIDTH-1:0]   rng_fold;
  logic                   slot_free;

  card_decoder u_decoder (
    .idx_i  (idx_q),
    .card_o (probe_card)
  );

  // Single fold is enough for any value the RNG can return with max = DECK_SIZE-1.
  assign rng_fold  = (i_rngValue >= RNG_WIDTH'(DECK_SIZE))
                   ? i_rngValue - RNG_WIDTH'(DECK_SIZE) : i_rngValue;
  assign slot_free = (idx_q < 6'(DECK_SIZE)) && !used_q[idx_q];

  always_comb begin
    state_d     = state_q;
    used_d      = used_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    card_d      = card_q;
    dealerr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_deal) begin
          if (empty_q) begin
            dealerr_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: state_d = CAPTURE;
      CAPTURE: begin
        idx_d   = rng_fold[5:0];
        state_d = PROBE;
      end
      PROBE: begin
        if (slot_free) begin
          used_d[idx_q] = 1'b1;
          card_d        = probe_card;
          remaining_d   = remaining_q - 6'd1;
          state_d       = DONE;
        end else begin
          idx_d = (idx_q >= 6'(DECK_SIZE - 1)) ? 6'd0 : idx_q + 6'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shuffle overrides everything, including a deal being sampled or completed.
    if (i_shuffle) begin
      used_d      = '0;
      remaining_d = 6'(DECK_SIZE);
      card_d      = card_q;
      dealerr_d   = 1'b0;
      state_d     = IDLE;
    end
  end

  assign empty_d = (remaining_d == 6'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      used_q      <= '0;
      remaining_q <= 6'(DECK_SIZE);
      idx_q       <= '0;
      card_q      <= '0;
      dealerr_q   <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      used_q      <= used_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      card_q      <= card_d;
      dealerr_q   <= dealerr_d;
      empty_q     <= empty_d;
    end
  end

  assign o_rngRequest = (state_q == REQ);
  assign o_rngMax     = RNG_WIDTH'(DECK_SIZE - 1);
  assign o_busy       = (state_q != IDLE);
  assign o_valid      = (state_q == DONE);
  assign o_rank       = card_q.rank;
  assign o_suit       = card_q.suit;
  assign o_points     = card_q.points;
  assign o_empty      = empty_q;
  assign o_dealError  = dealerr_q;
`ifdef CARD_DEALER_REMAINING_EN
  assign o_remaining  = remaining_q;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer; the bench itself plays the RNG by holding i_rngValue.
module tb_card_dealer;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_deal = 1'b0;
  logic       i_shuffle = 1'b0;
  logic [5:0] i_rngValue = '0;
  logic       o_rngRequest;
  logic [5:0] o_rngMax;
  logic       o_busy;
  logic       o_valid;
  logic [3:0] o_rank;
  logic [1:0] o_suit;
  logic [3:0] o_points;
  logic       o_empty;
  logic       o_dealError;
`ifdef CARD_DEALER_REMAINING_EN
  logic [5:0] o_remaining;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  card_dealer dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_deal       (i_deal),
    .i_shuffle    (i_shuffle),
    .o_rngRequest (o_rngRequest),
    .o_rngMax     (o_rngMax),
    .i_rngValue   (i_rngValue),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_rank       (o_rank),
    .o_suit       (o_suit),
    .o_points     (o_points),
    .o_empty      (o_empty),
    .o_dealError  (o_dealError)
`ifdef CARD_DEALER_REMAINING_EN
    ,.o_remaining (o_remaining)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Caller is at a negedge with the dealer in IDLE; returns at a negedge back in IDLE.
  task automatic do_deal(input string tag, input logic [5:0] rng, input int exp_lat,
                         input logic [3:0] er, input logic [1:0] es, input logic [3:0] ep,
                         input logic exp_empty);
    int  n;
    bit  seen;
    i_deal     = 1'b1;
    i_rngValue = rng;
    @(posedge i_clk);
    #1 i_deal = 1'b0;
    n    = 0;
    seen = 0;
    while (n < 80 && !seen) begin
      @(negedge i_clk);
      n++;
      if (n == 1) check({tag, ".rngreq"}, 32'(o_rngRequest), 32'd1);
      if (o_valid) seen = 1;
    end
    check({tag, ".latency"}, seen ? n : -1, exp_lat);
    check({tag, ".rank"},    32'(o_rank),   32'(er));
    check({tag, ".suit"},    32'(o_suit),   32'(es));
    check({tag, ".points"},  32'(o_points), 32'(ep));
    check({tag, ".empty"},   32'(o_empty),  32'(exp_empty));
    $display("deal %s rng=%0d lat=%0d rank=%0d suit=%0d points=%0d empty=%0d",
             tag, rng, n, o_rank, o_suit, o_points, o_empty);
    @(negedge i_clk);
  endtask

  task automatic pulse_shuffle();
    i_shuffle = 1'b1;
    @(negedge i_clk);
    i_shuffle = 1'b0;
  endtask

  initial begin
    int exp_idx;
    int vcount;

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst.rank",   32'(o_rank),       32'd0);
    check("rst.suit",   32'(o_suit),       32'd0);
    check("rst.points", 32'(o_points),     32'd0);
    check("rst.valid",  32'(o_valid),      32'd0);
    check("rst.busy",   32'(o_busy),       32'd0);
    check("rst.empty",  32'(o_empty),      32'd0);
    check("rst.derr",   32'(o_dealError),  32'd0);
    check("rst.rngreq", 32'(o_rngRequest), 32'd0);
    check("rst.rngmax", 32'(o_rngMax),     32'd51);
    i_reset = 1'b0;
    @(negedge i_clk);
`ifdef CARD_DEALER_REMAINING_EN
    check("rem.reset", 32'(o_remaining), 32'd52);
`endif

    do_deal("ace0", 6'd0, 4, 4'd1, 2'd0, 4'd11, 1'b0);
    do_deal("king0", 6'd12, 4, 4'd13, 2'd0, 4'd10, 1'b0);
`ifdef CARD_DEALER_REMAINING_EN
    check("rem.two", 32'(o_remaining), 32'd50);
`endif
    do_deal("queen2", 6'd37, 4, 4'd12, 2'd2, 4'd10, 1'b0);
    do_deal("six0", 6'd5, 4, 4'd6, 2'd0, 4'd6, 1'b0);
    do_deal("seven0", 6'd5, 5, 4'd7, 2'd0, 4'd7, 1'b0);

    pulse_shuffle();
    check("shuf.empty", 32'(o_empty), 32'd0);
    check("shuf.busy",  32'(o_busy),  32'd0);
`ifdef CARD_DEALER_REMAINING_EN
    check("rem.shuffle", 32'(o_remaining), 32'd52);
`endif

    // Whole deck with the RNG stuck at 51: probing walks 51, 0, 1, ... 50.
    for (int k = 0; k < 52; k++) begin
      exp_idx = (k == 0) ? 51 : k - 1;
      do_deal($sformatf("full%0d", k), 6'd51, 4 + k,
              4'(exp_idx % 13 + 1), 2'(exp_idx / 13),
              (exp_idx % 13 == 0) ? 4'd11 : ((exp_idx % 13 >= 10) ? 4'd10 : 4'(exp_idx % 13 + 1)),
              k == 51);
    end

    // 53rd deal on an empty deck
    i_deal = 1'b1;
    @(posedge i_clk);
    #1 i_deal = 1'b0;
    vcount = 0;
    @(negedge i_clk);
    check("empty.derr1", 32'(o_dealError), 32'd1);
    check("empty.busy",  32'(o_busy),      32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (c == 0) check("empty.derr2", 32'(o_dealError), 32'd0);
      if (o_valid) vcount++;
    end
    check("empty.novalid", vcount, 0);
    $display("deal empty53 derr_seen vcount=%0d", vcount);

    // Shuffle while probing (rng 10 lands in PROBE during the third cycle)
    pulse_shuffle();
    i_deal     = 1'b1;
    i_rngValue = 6'd10;
    @(posedge i_clk);
    #1 i_deal = 1'b0;
    repeat (3) @(negedge i_clk);
    i_shuffle = 1'b1;
    @(negedge i_clk);
    i_shuffle = 1'b0;
    check("probeshuf.busy",  32'(o_busy),  32'd0);
    check("probeshuf.empty", 32'(o_empty), 32'd0);
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (o_valid) vcount++;
    end
    check("probeshuf.novalid", vcount, 0);
    check("probeshuf.rank",    32'(o_rank), 32'd12);
    check("probeshuf.suit",    32'(o_suit), 32'd3);
    $display("deal probeshuf dropped vcount=%0d rank=%0d suit=%0d", vcount, o_rank, o_suit);
    do_deal("ace_after", 6'd0, 4, 4'd1, 2'd0, 4'd11, 1'b0);

    // Simultaneous deal and shuffle in IDLE: deal discarded
    i_deal    = 1'b1;
    i_shuffle = 1'b1;
    @(negedge i_clk);
    i_deal    = 1'b0;
    i_shuffle = 1'b0;
    check("dealshuf.busy",   32'(o_busy),       32'd0);
    check("dealshuf.rngreq", 32'(o_rngRequest), 32'd0);
    $display("deal dealshuf busy=%0d", o_busy);

    // i_deal while busy is not queued
    i_deal     = 1'b1;
    i_rngValue = 6'd20;
    @(posedge i_clk);
    #1 i_deal = 1'b0;
    @(negedge i_clk);
    i_deal = 1'b1;
    @(negedge i_clk);
    i_deal = 1'b0;
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (o_valid) vcount++;
    end
    check("busydeal.count", vcount, 1);
    check("busydeal.rank",  32'(o_rank), 32'd8);
    check("busydeal.suit",  32'(o_suit), 32'd1);
    $display("deal busydeal vcount=%0d rank=%0d suit=%0d", vcount, o_rank, o_suit);

    // Reset mid-deal
    i_deal     = 1'b1;
    i_rngValue = 6'd30;
    @(posedge i_clk);
    #1 i_deal = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("midrst.busy",  32'(o_busy),  32'd0);
    check("midrst.rank",  32'(o_rank),  32'd0);
    check("midrst.valid", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_valid) vcount++;
    end
    check("midrst.novalid", vcount, 0);
    check("midrst.empty",   32'(o_empty), 32'd0);
    $display("deal midreset vcount=%0d", vcount);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
